// File: rtl/dec_sel_sequencer_if.sv
// Handshake/bus bundle between the select sequencer and its controller/consumer.
// Combinational bundle only: no storage, no added latency.
// Backpressure is carried by ack; the sequencer holds its code while ack is low.
interface dec_sel_sequencer_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic       dir;
  logic       ld;
  logic [1:0] ld_val;
  logic       ack;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       step;
  logic       done;

  // Controller / consumer side: drives commands and ack, observes the code.
  modport master (
    output start, stop, mode, dir, ld, ld_val, ack,
    input  s1, s0, busy, step, done
  );

  // Sequencer side.
  modport slave (
    input  start, stop, mode, dir, ld, ld_val, ack,
    output s1, s0, busy, step, done
  );
endinterface

// File: rtl/dec_sel_sequencer.sv
// Generates the 2-bit decoder select code, stepping up/down with a programmable dwell.
// All outputs registered; a new code appears DWELL cycles after start / the previous code.
// Holds the current code (no step) while ack is low once the dwell has expired.
module dec_sel_sequencer #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  dec_sel_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [1:0]    code_q,  code_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    vcnt_q,  vcnt_d;
  logic          sweep_q, sweep_d;
  logic          step_q,  step_d;
  logic          done_q,  done_d;

  // Next-state: stop beats ld, ld beats start/advance; step/done are one-shot.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    vcnt_d  = vcnt_q;
    sweep_d = sweep_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    if (bus.stop && state_q == RUN) begin
      // Abort freezes the code where it stands.
      state_d = IDLE;
    end else if (bus.ld) begin
      code_d = bus.ld_val;
      if (state_q == RUN) begin
        // A load mid-run restarts both the dwell and the sweep count.
        cnt_d  = DWELL_M1;
        vcnt_d = 2'd0;
      end
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = RUN;
        cnt_d   = DWELL_M1;
        vcnt_d  = 2'd0;
        sweep_d = bus.mode;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (bus.ack) begin
        if (sweep_q && vcnt_q == 2'd3) begin
          // Fourth code has had its dwell: sweep complete, code stays.
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          code_d = bus.dir ? (code_q - 2'd1) : (code_q + 2'd1);
          cnt_d  = DWELL_M1;
          vcnt_d = vcnt_q + 2'd1;
          step_d = 1'b1;
        end
      end
      // cnt==0 with ack low: hold everything, ack is not remembered.
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 2'd0;
      cnt_q   <= '0;
      vcnt_q  <= 2'd0;
      sweep_q <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      vcnt_q  <= vcnt_d;
      sweep_q <= sweep_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.s1   = code_q[1];
  assign bus.s0   = code_q[0];
  assign bus.busy = (state_q == RUN);
  assign bus.step = step_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Directed bench for dec_sel_sequencer: DWELL=4 instance plus a DWELL=1 instance.
// Outputs are sampled 1 time unit after each rising edge.
// ack is driven directly to exercise hold/advance behaviour.
module tb_dec_sel_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dec_sel_sequencer_if a ();
  dec_sel_sequencer_if b ();

  dec_sel_sequencer #(.DWELL(4), .CW(8)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  dec_sel_sequencer #(.DWELL(1), .CW(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all outputs of the DWELL=4 instance.
  task automatic chk_a(input string tag, input logic [1:0] code, input logic busy,
                       input logic step, input logic done);
    chk({tag, ".code"}, {6'd0, a.s1, a.s0}, {6'd0, code});
    chk({tag, ".busy"}, {7'd0, a.busy}, {7'd0, busy});
    chk({tag, ".step"}, {7'd0, a.step}, {7'd0, step});
    chk({tag, ".done"}, {7'd0, a.done}, {7'd0, done});
  endtask

  task automatic chk_b(input string tag, input logic [1:0] code, input logic step);
    chk({tag, ".code"}, {6'd0, b.s1, b.s0}, {6'd0, code});
    chk({tag, ".step"}, {7'd0, b.step}, {7'd0, step});
  endtask

  initial begin
    logic [1:0] cur;
    logic [1:0] seq_dn [3];

    n_tests = 0;
    n_fail  = 0;
    {a.start, a.stop, a.mode, a.dir, a.ld, a.ack} = '0;
    a.ld_val = 2'd0;
    {b.start, b.stop, b.mode, b.dir, b.ld, b.ack} = '0;
    b.ld_val = 2'd0;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk_a("rst", 2'b00, 1'b0, 1'b0, 1'b0);
    chk_b("rst1", 2'b00, 1'b0);
    chk({"rst1.busy"}, {7'd0, b.busy}, 8'd0);
    rst = 1'b0;

    // Continuous up from 00, DWELL=4, ack high
    a.ack = 1'b1; a.mode = 1'b0; a.dir = 1'b0; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    chk_a("cont.start", 2'b00, 1'b1, 1'b0, 1'b0);
    cur = 2'b00;
    for (int c = 0; c < 4; c++) begin
      for (int t = 1; t <= 4; t++) begin
        tick();
        if (t == 4) cur = cur + 2'd1;
        chk_a($sformatf("cont.c%0d.t%0d", c, t), cur, 1'b1, (t == 4), 1'b0);
      end
    end

    // stop mid-dwell: code frozen, busy drops, no done
    tick();
    tick();
    a.stop = 1'b1;
    tick();
    a.stop = 1'b0;
    chk_a("stop", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk_a("stop.hold", 2'b00, 1'b0, 1'b0, 1'b0);

    // Single sweep down from 01
    a.ld = 1'b1; a.ld_val = 2'b01;
    tick();
    a.ld = 1'b0;
    chk_a("sweep.ld", 2'b01, 1'b0, 1'b0, 1'b0);
    a.mode = 1'b1; a.dir = 1'b1; a.start = 1'b1;
    tick();
    a.start = 1'b0; a.mode = 1'b0;
    chk_a("sweep.start", 2'b01, 1'b1, 1'b0, 1'b0);
    seq_dn[0] = 2'b00; seq_dn[1] = 2'b11; seq_dn[2] = 2'b10;
    cur = 2'b01;
    for (int c = 0; c < 3; c++) begin
      for (int t = 1; t <= 4; t++) begin
        tick();
        if (t == 4) cur = seq_dn[c];
        chk_a($sformatf("sweep.c%0d.t%0d", c, t), cur, 1'b1, (t == 4), 1'b0);
      end
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk_a($sformatf("sweep.last.t%0d", t), 2'b10, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_a("sweep.done", 2'b10, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("sweep.after", 2'b10, 1'b0, 1'b0, 1'b0);

    // Backpressure: ack low for 5 cycles after dwell expiry
    a.dir = 1'b0; a.ack = 1'b0; a.start = 1'b1;
    tick();
    a.start = 1'b0;
    chk_a("bp.start", 2'b10, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk_a($sformatf("bp.hold%0d", t), 2'b10, 1'b1, 1'b0, 1'b0);
    end
    a.ack = 1'b1;
    tick();
    chk_a("bp.adv", 2'b11, 1'b1, 1'b1, 1'b0);

    // ld coincident with a pending advance: ld wins, no step
    tick();
    tick();
    tick();
    chk_a("coll.pre", 2'b11, 1'b1, 1'b0, 1'b0);
    a.ld = 1'b1; a.ld_val = 2'b11;
    tick();
    a.ld = 1'b0;
    chk_a("coll.ld", 2'b11, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk_a($sformatf("coll.t%0d", t), 2'b11, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_a("coll.adv", 2'b00, 1'b1, 1'b1, 1'b0);
    a.stop = 1'b1;
    tick();
    a.stop = 1'b0;
    chk_a("coll.stop", 2'b00, 1'b0, 1'b0, 1'b0);

    // ld with start in IDLE: load only
    a.ld = 1'b1; a.ld_val = 2'b10; a.start = 1'b1;
    tick();
    a.ld = 1'b0; a.start = 1'b0;
    chk_a("ldstart", 2'b10, 1'b0, 1'b0, 1'b0);

    // Reset landing on an advance edge suppresses the step
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_a("rstmid", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("rstmid2", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // DWELL=1: advance every cycle, dir reversal on next advance
    b.ack = 1'b1; b.start = 1'b1;
    tick();
    b.start = 1'b0;
    chk_b("d1.start", 2'b00, 1'b0);
    chk("d1.busy", {7'd0, b.busy}, 8'd1);
    cur = 2'b00;
    for (int t = 1; t <= 4; t++) begin
      tick();
      cur = cur + 2'd1;
      chk_b($sformatf("d1.up%0d", t), cur, 1'b1);
    end
    b.dir = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      tick();
      cur = cur - 2'd1;
      chk_b($sformatf("d1.dn%0d", t), cur, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
